// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: op codes, FSM state
// encodings and the read-modify-write merge helper.
package reg_bus_pkg;

    // Command op codes carried on cmd_op_i.
    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_RMW     = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_CAPT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_RSP      = 3'd4;

    // Widest data bus the merge helper supports; callers size-cast in and out.
    localparam int MERGE_W = 256;

    // Bits set in mask take their value from new_val, the rest keep old_val.
    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0] old_val,
        input logic [MERGE_W-1:0] new_val,
        input logic [MERGE_W-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: takes one command at a time on a valid/ready port,
// drives the write/read strobes of the simple register bus and returns a
// response. RMW holds off new commands between its read and its write, which
// makes it atomic with respect to this initiator.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                sysclk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W/8-1:0] cmd_byte_sel_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W-1:0]   cmd_mask_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                wr_ena_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [DATA_W/8-1:0] wr_byte_sel_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic                rd_ena_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic [DATA_W-1:0]   rd_data_i
);

    localparam int BSEL_W = DATA_W / 8;

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic              hs_s;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] mask_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] merged_s;

    // Command handshake can only fire while idle.
    assign hs_s = cmd_valid_i & cmd_ready_o & (state_r == ST_IDLE);

    // Merged write value for RMW, formed from the read data being captured now.
    assign merged_s = DATA_W'(merge(MERGE_W'(rd_data_i), MERGE_W'(wdata_r), MERGE_W'(mask_r)));

    // Next-state decode of the command FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    case (cmd_op_i)
                        OP_READ:  state_next_s = ST_RD_ISSUE;
                        OP_RMW:   state_next_s = ST_RD_ISSUE;
                        OP_WRITE: state_next_s = ST_WR_ISSUE;
                        default:  state_next_s = ST_RSP;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: state_next_s = ST_RD_CAPT;
            ST_RD_CAPT: begin
                if (op_r == OP_RMW) begin
                    state_next_s = ST_WR_ISSUE;
                end else begin
                    state_next_s = ST_RSP;
                end
            end
            ST_WR_ISSUE: state_next_s = ST_RSP;
            ST_RSP: begin
                if (rsp_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RSP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and control outputs, all registered from the next state.
    // cmd_ready_o rises only after a full idle cycle, so a new command is taken
    // one cycle after the response handshake.
    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            rd_ena_o    <= 1'b0;
            wr_ena_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_ready_o <= (state_r == ST_IDLE) && !hs_s;
            busy_o      <= (state_next_s != ST_IDLE);
            rd_ena_o    <= (state_next_s == ST_RD_ISSUE);
            wr_ena_o    <= (state_next_s == ST_WR_ISSUE);
            rsp_valid_o <= (state_next_s == ST_RSP);
        end
    end

    // Command latch, bus address/data outputs and response payload.
    // Bus address and data outputs hold their last value while strobes are low.
    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            op_r          <= OP_READ;
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            mask_r        <= {DATA_W{1'b0}};
            rdata_r       <= {DATA_W{1'b0}};
            rd_addr_o     <= {ADDR_W{1'b0}};
            wr_addr_o     <= {ADDR_W{1'b0}};
            wr_byte_sel_o <= {BSEL_W{1'b0}};
            wr_data_o     <= {DATA_W{1'b0}};
            rsp_rdata_o   <= {DATA_W{1'b0}};
            rsp_err_o     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        op_r    <= cmd_op_i;
                        addr_r  <= cmd_addr_i;
                        wdata_r <= cmd_wdata_i;
                        mask_r  <= cmd_mask_i;
                        case (cmd_op_i)
                            OP_READ:  rd_addr_o <= cmd_addr_i;
                            OP_RMW:   rd_addr_o <= cmd_addr_i;
                            OP_WRITE: begin
                                wr_addr_o     <= cmd_addr_i;
                                wr_byte_sel_o <= cmd_byte_sel_i;
                                wr_data_o     <= cmd_wdata_i;
                            end
                            default: begin
                                rsp_rdata_o <= {DATA_W{1'b0}};
                                rsp_err_o   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD_CAPT: begin
                    rdata_r <= rd_data_i;
                    if (op_r == OP_RMW) begin
                        wr_addr_o     <= addr_r;
                        wr_byte_sel_o <= {BSEL_W{1'b1}};
                        wr_data_o     <= merged_s;
                    end else begin
                        rsp_rdata_o <= rd_data_i;
                        rsp_err_o   <= 1'b0;
                    end
                end
                ST_WR_ISSUE: begin
                    rsp_err_o <= 1'b0;
                    if (op_r == OP_RMW) begin
                        rsp_rdata_o <= rdata_r;
                    end else begin
                        rsp_rdata_o <= {DATA_W{1'b0}};
                    end
                end
                default: begin
                    rsp_err_o <= rsp_err_o;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed self-checking bench for reg_bus_master with a small GPIO-style
// register slave (16 x 32-bit registers, byte enables, registered read data).
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [3:0]  cmd_byte_sel;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        wr_ena;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_byte_sel;
    logic [31:0] wr_data;
    logic        rd_ena;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;

    logic [31:0] slave_regs [16];

    reg_bus_master #(.ADDR_W(4), .DATA_W(32)) dut (
        .sysclk_i       (clk),
        .reset_i        (reset),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_addr_i     (cmd_addr),
        .cmd_byte_sel_i (cmd_byte_sel),
        .cmd_wdata_i    (cmd_wdata),
        .cmd_mask_i     (cmd_mask),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .busy_o         (busy),
        .wr_ena_o       (wr_ena),
        .wr_addr_o      (wr_addr),
        .wr_byte_sel_o  (wr_byte_sel),
        .wr_data_o      (wr_data),
        .rd_ena_o       (rd_ena),
        .rd_addr_o      (rd_addr),
        .rd_data_i      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave: byte-enabled writes, read data registered one cycle after rd_ena.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) slave_regs[i] <= 32'h0;
            rd_data <= 32'h0;
        end else begin
            if (wr_ena) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_byte_sel[b]) slave_regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            if (rd_ena) rd_data <= slave_regs[rd_addr];
        end
    end

    // Strobe counters for "no extra bus activity" and exclusivity checks.
    always @(posedge clk) begin
        if (wr_ena) wr_cnt <= wr_cnt + 1;
        if (rd_ena) rd_cnt <= rd_cnt + 1;
        if (wr_ena && rd_ena) both_cnt <= both_cnt + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for cmd_ready, then present one command for one cycle.
    // Returns positioned in cycle A+1.
    task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] bsel,
                        input logic [31:0] wdata, input logic [31:0] mask);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
        cmd_op       = op;
        cmd_addr     = addr;
        cmd_byte_sel = bsel;
        cmd_wdata    = wdata;
        cmd_mask     = mask;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [3:0] bsel, input logic [31:0] data);
        send(OP_WRITE, addr, bsel, data, 32'h0);
        chk("wr_ena_a1", {31'h0, wr_ena}, 32'h1);
        chk("wr_addr_a1", {28'h0, wr_addr}, {28'h0, addr});
        chk("wr_bsel_a1", {28'h0, wr_byte_sel}, {28'h0, bsel});
        chk("wr_data_a1", wr_data, data);
        chk("wr_rd_ena_a1", {31'h0, rd_ena}, 32'h0);
        chk("wr_busy_a1", {31'h0, busy}, 32'h1);
        tick();
        chk("wr_rsp_valid_a2", {31'h0, rsp_valid}, 32'h1);
        chk("wr_rsp_err_a2", {31'h0, rsp_err}, 32'h0);
        chk("wr_rsp_rdata_a2", rsp_rdata, 32'h0);
        chk("wr_ena_a2", {31'h0, wr_ena}, 32'h0);
        tick();
        chk("wr_rsp_done", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
        send(OP_READ, addr, 4'h0, 32'h0, 32'h0);
        chk("rd_ena_a1", {31'h0, rd_ena}, 32'h1);
        chk("rd_addr_a1", {28'h0, rd_addr}, {28'h0, addr});
        chk("rd_wr_ena_a1", {31'h0, wr_ena}, 32'h0);
        tick();
        chk("rd_ena_a2", {31'h0, rd_ena}, 32'h0);
        chk("rd_rsp_valid_a2", {31'h0, rsp_valid}, 32'h0);
        tick();
        chk("rd_rsp_valid_a3", {31'h0, rsp_valid}, 32'h1);
        chk("rd_rsp_rdata_a3", rsp_rdata, exp);
        chk("rd_rsp_err_a3", {31'h0, rsp_err}, 32'h0);
        tick();
        chk("rd_rsp_done", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic do_rmw(input logic [3:0] addr, input logic [31:0] mask, input logic [31:0] wdata,
                          input logic [31:0] old_val, input logic [31:0] new_val);
        send(OP_RMW, addr, 4'h0, wdata, mask);
        chk("rmw_rd_ena_a1", {31'h0, rd_ena}, 32'h1);
        tick();
        chk("rmw_strobes_a2", {30'h0, wr_ena, rd_ena}, 32'h0);
        chk("rmw_cmd_ready_a2", {31'h0, cmd_ready}, 32'h0);
        tick();
        chk("rmw_wr_ena_a3", {31'h0, wr_ena}, 32'h1);
        chk("rmw_wr_data_a3", wr_data, new_val);
        chk("rmw_wr_bsel_a3", {28'h0, wr_byte_sel}, 32'hF);
        chk("rmw_wr_addr_a3", {28'h0, wr_addr}, {28'h0, addr});
        tick();
        chk("rmw_rsp_valid_a4", {31'h0, rsp_valid}, 32'h1);
        chk("rmw_rsp_rdata_a4", rsp_rdata, old_val);
        chk("rmw_rsp_err_a4", {31'h0, rsp_err}, 32'h0);
        tick();
    endtask

    initial begin
        int w0;
        int r0;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'd0;
        cmd_addr     = 4'h0;
        cmd_byte_sel = 4'h0;
        cmd_wdata    = 32'h0;
        cmd_mask     = 32'h0;
        rsp_ready    = 1'b1;

        // Power-on reset.
        tick(); tick(); tick();
        chk("reset_ctrl", {26'h0, cmd_ready, busy, rsp_valid, rsp_err, wr_ena, rd_ena}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;

        // Reset mid-READ, right after rd_ena is issued.
        send(OP_READ, 4'h5, 4'h0, 32'h0, 32'h0);
        chk("midrd_rd_ena", {31'h0, rd_ena}, 32'h1);
        reset = 1'b1;
        tick();
        chk("midrd_ctrl", {26'h0, cmd_ready, busy, rsp_valid, rsp_err, wr_ena, rd_ena}, 32'h0);
        chk("midrd_rd_addr", {28'h0, rd_addr}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("midrd_no_rsp1", {31'h0, rsp_valid}, 32'h0);
        tick();
        chk("midrd_no_rsp2", {30'h0, rsp_valid, busy}, 32'h0);
        do_write(4'h3, 4'hF, 32'h000000C3);
        do_read(4'h3, 32'h000000C3);

        // WRITE then READ on GPIO address 0.
        do_write(4'h0, 4'hF, 32'h000000A5);
        do_read(4'h0, 32'h000000A5);

        // RMW: low nibble replaced with 3.
        do_rmw(4'h0, 32'h0000000F, 32'h00000003, 32'h000000A5, 32'h000000A3);
        do_read(4'h0, 32'h000000A3);

        // Byte-select WRITE: only byte 1 updated.
        do_write(4'h0, 4'hF, 32'h000000A5);
        do_write(4'h0, 4'b0010, 32'h12345678);
        do_read(4'h0, 32'h000056A5);

        // Response backpressure with command pulses during the stall.
        rsp_ready = 1'b0;
        send(OP_READ, 4'h0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            cmd_valid    = (i % 2 == 0);
            cmd_op       = OP_WRITE;
            cmd_addr     = 4'h0;
            cmd_byte_sel = 4'hF;
            cmd_wdata    = 32'hFFFFFFFF;
            tick();
            chk("bp_valid_hold", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rdata_hold", rsp_rdata, 32'h000056A5);
            chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        end
        cmd_valid = 1'b0;
        chk("bp_no_wr", wr_cnt - w0, 32'h0);
        chk("bp_no_rd", rd_cnt - r0, 32'h0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_rsp_done", {31'h0, rsp_valid}, 32'h0);
        do_read(4'h0, 32'h000056A5);

        // Illegal op: immediate error response, no bus activity.
        w0 = wr_cnt;
        r0 = rd_cnt;
        send(OP_ILLEGAL, 4'h7, 4'hF, 32'hDEADBEEF, 32'h0);
        chk("ill_rsp_valid_a1", {31'h0, rsp_valid}, 32'h1);
        chk("ill_rsp_err_a1", {31'h0, rsp_err}, 32'h1);
        chk("ill_rsp_rdata_a1", rsp_rdata, 32'h0);
        chk("ill_strobes_a1", {30'h0, wr_ena, rd_ena}, 32'h0);
        tick();
        chk("ill_rsp_done", {31'h0, rsp_valid}, 32'h0);
        tick(); tick();
        chk("ill_no_wr", wr_cnt - w0, 32'h0);
        chk("ill_no_rd", rd_cnt - r0, 32'h0);
        do_read(4'h3, 32'h000000C3);

        chk("bus_exclusive", both_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the team's simple register bus: wr_ena/addr/byte_sel/data for writes; rd_ena/addr for reads, with rd_data returned one cycle later.
- Accepts one command at a time on a valid/ready command port and issues the bus strobes.
- Returns a response on a valid/ready response port; supports READ, WRITE and atomic read-modify-write (RMW).
- Sits between a host-side controller (UART/SPI command decoder, CPU shim) and register slaves such as the GPIO block.

Parameters:
- ADDR_W, 4, bus address width; passed through unmodified, slave decodes.
- DATA_W, 32, bus data width; must be a multiple of 8.

Ports:
- sysclk_i  input  1  system clock.
- reset_i  input  1  reset, active-high.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
- cmd_op_i  input  2  0=READ, 1=WRITE, 2=RMW, 3=illegal.
- cmd_addr_i  input  ADDR_W  target address.
- cmd_byte_sel_i  input  DATA_W/8  byte enables; used by WRITE only.
- cmd_wdata_i  input  DATA_W  write data; new-bit values for RMW.
- cmd_mask_i  input  DATA_W  RMW bit mask; 1 = replace bit.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  DATA_W  read data (READ), pre-modify value (RMW), 0 (WRITE).
- rsp_err_o  output  1  illegal op.
- busy_o  output  1  state != IDLE.
- wr_ena_o  output  1  bus write strobe.
- wr_addr_o  output  ADDR_W  bus write address.
- wr_byte_sel_o  output  DATA_W/8  bus byte enables.
- wr_data_o  output  DATA_W  bus write data.
- rd_ena_o  output  1  bus read strobe.
- rd_addr_o  output  ADDR_W  bus read address.
- rd_data_i  input  DATA_W  registered slave read data, valid the cycle after rd_ena_o.

Behaviour:
- Clock and reset: one clock, sysclk_i. Reset is synchronous and active-high (reset_i).
- Reset values: all outputs registered, all 0 during and after reset; state=IDLE; latched command discarded.
- Reset mid-operation: no further strobes in the following cycle; a pending response is dropped.
- States: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, RSP.
- cmd_ready_o = 1 only in IDLE. Handshake fires when cmd_valid_i & cmd_ready_o; op, addr, byte_sel, wdata and mask are latched.
- IDLE transitions on handshake:
  - READ or RMW -> RD_ISSUE.
  - WRITE -> WR_ISSUE.
  - illegal -> RSP with rsp_err_o=1, rdata=0, no bus activity.
- RD_ISSUE: rd_ena_o=1 for exactly one cycle, rd_addr_o=addr -> RD_CAPT.
- RD_CAPT: rd_data_i is sampled into rdata register at end of this cycle.
  - READ -> RSP.
  - RMW -> WR_ISSUE with wr_data = (rdata & ~mask) | (wdata & mask) and byte_sel all-ones.
- WR_ISSUE: wr_ena_o=1 for exactly one cycle, with wr_addr_o, wr_byte_sel_o and wr_data_o -> RSP.
- RSP: rsp_valid_o=1; rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i. On rsp_ready_i -> IDLE, rsp_valid_o=0 next cycle.
- Latency, handshake at cycle A:
  - WRITE: wr_ena_o in A+1, rsp_valid_o in A+2.
  - READ: rd_ena_o in A+1, rsp_valid_o in A+3.
  - RMW: rd_ena_o in A+1, wr_ena_o in A+3, rsp_valid_o in A+4.
  - Illegal op: rsp_valid_o in A+1.
- Back-to-back: with rsp_ready_i held high, the next command is accepted one cycle after the response handshake. Sustained WRITE period is 4 cycles.
- Bus exclusivity: wr_ena_o and rd_ena_o are never high in the same cycle. Address and data outputs hold their last value when strobes are low.
- Ignored inputs: cmd_valid_i while not IDLE is ignored (no latch). rsp_ready_i outside RSP is ignored.
- RMW atomicity: no other command is accepted between the RMW read and write.

Decomposition:
- Shared package reg_bus_pkg:
  - op codes OP_READ, OP_WRITE, OP_RMW.
  - state encodings.
  - RMW merge function merge(old, new, mask).
- No sub-module. Single FSM plus datapath registers in one module.
- Bench pairs it with the GPIO register block as the slave.

Test Plan:
- Reset: hold reset_i 3 cycles mid-READ (rd_ena_o just issued) -> all outputs 0 next cycle, busy_o=0, no rsp_valid_o; the next command proceeds normally.
- WRITE then READ to GPIO addr 0x0: data 0x000000A5, byte_sel 4'hF, direction register 0 -> write response rsp_err_o=0 at A+2; READ response rsp_rdata_o=0x000000A5 at A+3.
- Byte-select WRITE: after the 0x000000A5 write, WRITE 0x12345678 with byte_sel 4'b0010 to addr 0x0 -> readback 0x000056A5.
- RMW on addr 0x0: starting value 0x000000A5, mask 0x0000000F, wdata 0x00000003 -> bus write 0x000000A3 with byte_sel 4'hF; rsp_rdata_o=0x000000A5; readback 0x000000A3.
- Response backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and rsp_rdata_o stable; cmd_valid_i pulses during the stall are not accepted (cmd_ready_o=0); no extra strobes.
- Illegal op 3 -> rsp_err_o=1 at A+1; wr_ena_o and rd_ena_o stay 0 throughout.
